// File: rtl/ssd1306_spi_tx.sv
// ssd1306_spi_tx: write-only SPI mode-0 master for an external SSD1306 panel.
// Runs the panel reset sequence (RES# pulse, then settle time), then serialises
// command/data bytes offered over valid/ready, MSB first. CS is held low across
// back-to-back bytes and released after a short idle timeout.
module ssd1306_spi_tx #(
  parameter int CLK_DIV          = 2,
  parameter int RST_PULSE_CYCLES = 160,
  parameter int RST_WAIT_CYCLES  = 1600,
  parameter int CS_IDLE_CYCLES   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rst_req_i,
  input  logic [7:0] data_i,
  input  logic       dc_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       ss_o,
  output logic       scl_o,
  output logic       mosi_o,
  output logic       dc_o,
  output logic       oled_rst_o
);

  // Counter width covers the largest programmable interval.
  localparam int MAX_AB = (RST_PULSE_CYCLES > RST_WAIT_CYCLES) ? RST_PULSE_CYCLES : RST_WAIT_CYCLES;
  localparam int MAX_CD = (CS_IDLE_CYCLES > CLK_DIV) ? CS_IDLE_CYCLES : CLK_DIV;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  // Terminal values: an interval of K cycles ends on the cycle the counter holds K-1.
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RST_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_RST_PULSE = 3'd0,
    ST_RST_WAIT  = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;     // reset pulse / reset wait / CS idle timer
  logic [CNT_W-1:0] div_reg, div_next;     // SCK half-period timer
  logic [2:0]       bit_reg, bit_next;     // bit index within the current byte
  logic [7:0]       sr_reg, sr_next;       // outgoing byte, MSB at [7]
  logic             ss_reg, ss_next;
  logic             scl_reg, scl_next;
  logic             mosi_reg, mosi_next;
  logic             dc_reg, dc_next;
  logic             ready_reg, ready_next;
  logic             oled_rst_reg, oled_rst_next;
  logic             accept;
  logic             do_load;

  // Saturating increment so a counter can never wrap back into range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign accept = valid_i & ready_reg;

  // State and output registers; asynchronous reset returns to the reset-pulse state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= ST_RST_PULSE;
      cnt_reg      <= '0;
      div_reg      <= '0;
      bit_reg      <= '0;
      sr_reg       <= '0;
      ss_reg       <= 1'b1;
      scl_reg      <= 1'b0;
      mosi_reg     <= 1'b0;
      dc_reg       <= 1'b0;
      ready_reg    <= 1'b0;
      oled_rst_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      div_reg      <= div_next;
      bit_reg      <= bit_next;
      sr_reg       <= sr_next;
      ss_reg       <= ss_next;
      scl_reg      <= scl_next;
      mosi_reg     <= mosi_next;
      dc_reg       <= dc_next;
      ready_reg    <= ready_next;
      oled_rst_reg <= oled_rst_next;
    end
  end

  // Next-state and registered-output logic; rst_req_i overrides everything last.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    div_next      = div_reg;
    bit_next      = bit_reg;
    sr_next       = sr_reg;
    ss_next       = ss_reg;
    scl_next      = scl_reg;
    mosi_next     = mosi_reg;
    dc_next       = dc_reg;
    ready_next    = ready_reg;
    oled_rst_next = oled_rst_reg;
    do_load       = 1'b0;

    case (state_reg)
      ST_RST_PULSE: begin
        oled_rst_next = 1'b0;
        ss_next       = 1'b1;
        ready_next    = 1'b0;
        if (cnt_reg >= PULSE_LAST) begin
          state_next    = ST_RST_WAIT;
          cnt_next      = '0;
          oled_rst_next = 1'b1;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end

      ST_RST_WAIT: begin
        if (cnt_reg >= WAIT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          ready_next = 1'b1;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end

      ST_IDLE: begin
        if (accept) begin
          do_load = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (div_reg >= DIV_LAST) begin
          div_next = '0;
          if (!scl_reg) begin
            // Rising edge: panel samples the bit already on mosi.
            scl_next = 1'b1;
          end else begin
            // Falling edge: either advance to the next bit or finish the byte.
            scl_next = 1'b0;
            if (bit_reg == 3'd7) begin
              bit_next   = 3'd0;
              state_next = ST_HOLD;
              ready_next = 1'b1;
              cnt_next   = '0;
            end else begin
              bit_next  = bit_reg + 3'd1;
              sr_next   = {sr_reg[6:0], 1'b0};
              mosi_next = sr_reg[6];
            end
          end
        end else begin
          div_next = sat_inc(div_reg);
        end
      end

      ST_HOLD: begin
        // A byte arriving on the timeout cycle still wins, keeping CS low.
        if (accept) begin
          do_load = 1'b1;
        end else if (cnt_reg >= IDLE_LAST) begin
          ss_next    = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt_reg);
        end
      end

      default: begin
        state_next = ST_RST_PULSE;
        cnt_next   = '0;
      end
    endcase

    // Byte load: latch data/dc, drive first bit, start the low half of bit 7.
    if (do_load) begin
      sr_next    = data_i;
      dc_next    = dc_i;
      mosi_next  = data_i[7];
      ss_next    = 1'b0;
      scl_next   = 1'b0;
      ready_next = 1'b0;
      div_next   = '0;
      bit_next   = '0;
      cnt_next   = '0;
      state_next = ST_SHIFT;
    end

    // Reset request drops any byte in flight and reruns the panel reset.
    if (rst_req_i) begin
      state_next    = ST_RST_PULSE;
      ss_next       = 1'b1;
      scl_next      = 1'b0;
      mosi_next     = 1'b0;
      ready_next    = 1'b0;
      oled_rst_next = 1'b0;
      cnt_next      = '0;
      div_next      = '0;
      bit_next      = '0;
    end
  end

  assign ready_o    = ready_reg;
  assign busy_o     = (state_reg != ST_IDLE);
  assign ss_o       = ss_reg;
  assign scl_o      = scl_reg;
  assign mosi_o     = mosi_reg;
  assign dc_o       = dc_reg;
  assign oled_rst_o = oled_rst_reg;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// tb_ssd1306_spi_tx: directed checks on a CLK_DIV=2 instance plus a randomised
// byte stream on a CLK_DIV=1 instance, each observed by an SPI receiver model.
module tb_ssd1306_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance 0: CLK_DIV = 2
  logic       rst_req0, dc0, valid0;
  logic [7:0] data0;
  logic       ready0, busy0, ss0, scl0, mosi0, dc_out0, oled_rst0;

  // Instance 1: CLK_DIV = 1
  logic       rst_req1, dc1, valid1;
  logic [7:0] data1;
  logic       ready1, busy1, ss1, scl1, mosi1, dc_out1, oled_rst1;

  ssd1306_spi_tx #(.CLK_DIV(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .rst_req_i(rst_req0), .data_i(data0), .dc_i(dc0),
    .valid_i(valid0), .ready_o(ready0), .busy_o(busy0), .ss_o(ss0), .scl_o(scl0),
    .mosi_o(mosi0), .dc_o(dc_out0), .oled_rst_o(oled_rst0)
  );

  ssd1306_spi_tx #(.CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .rst_req_i(rst_req1), .data_i(data1), .dc_i(dc1),
    .valid_i(valid1), .ready_o(ready1), .busy_o(busy1), .ss_o(ss1), .scl_o(scl1),
    .mosi_o(mosi1), .dc_o(dc_out1), .oled_rst_o(oled_rst1)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver model 0: shifts mosi on each SCK rise while CS is low.
  logic       scl0_p = 1'b0, ss0_p = 1'b1, rx0_dc = 1'b0;
  logic [7:0] rx0_sr = 8'h00;
  int         rx0_bits = 0, all_rises0 = 0, sclbad0 = 0, dcbad0 = 0;
  logic [8:0] rx0_q[$];

  always @(negedge clk) begin
    if (ss0 && ss0_p && (scl0 != scl0_p)) sclbad0++;
    if (scl0 && !scl0_p) all_rises0++;
    if (ss0) begin
      rx0_bits = 0;
    end else if (scl0 && !scl0_p) begin
      if (rx0_bits == 0) rx0_dc = dc_out0;
      else if (dc_out0 !== rx0_dc) dcbad0++;
      rx0_sr = {rx0_sr[6:0], mosi0};
      rx0_bits++;
      if (rx0_bits == 8) begin
        rx0_q.push_back({rx0_dc, rx0_sr});
        rx0_bits = 0;
      end
    end
    scl0_p = scl0;
    ss0_p  = ss0;
  end

  // Receiver model 1
  logic       scl1_p = 1'b0, ss1_p = 1'b1, rx1_dc = 1'b0;
  logic [7:0] rx1_sr = 8'h00;
  int         rx1_bits = 0, sclbad1 = 0, dcbad1 = 0;
  logic [8:0] rx1_q[$];

  always @(negedge clk) begin
    if (ss1 && ss1_p && (scl1 != scl1_p)) sclbad1++;
    if (ss1) begin
      rx1_bits = 0;
    end else if (scl1 && !scl1_p) begin
      if (rx1_bits == 0) rx1_dc = dc_out1;
      else if (dc_out1 !== rx1_dc) dcbad1++;
      rx1_sr = {rx1_sr[6:0], mosi1};
      rx1_bits++;
      if (rx1_bits == 8) begin
        rx1_q.push_back({rx1_dc, rx1_sr});
        rx1_bits = 0;
      end
    end
    scl1_p = scl1;
    ss1_p  = ss1;
  end

  initial begin
    int n, r, sshigh, ssbad, timeouts, gap;
    logic acc;
    logic [8:0] got, exp_b;
    logic [8:0] exp_q[$];

    rst_n = 1'b1;
    rst_req0 = 1'b0; dc0 = 1'b0; valid0 = 1'b0; data0 = 8'h00;
    rst_req1 = 1'b0; dc1 = 1'b0; valid1 = 1'b0; data1 = 8'h00;
    #2 rst_n = 1'b0;
    #20;

    // Reset values
    check("rst_oled_rst", oled_rst0, 0);
    check("rst_ss", ss0, 1);
    check("rst_scl", scl0, 0);
    check("rst_mosi", mosi0, 0);
    check("rst_dc", dc_out0, 0);
    check("rst_ready", ready0, 0);
    check("rst_busy", busy0, 1);

    // Reset release: RES# low 160 cycles, then 1600 cycles to ready
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0; ssbad = 0;
    while (oled_rst0 !== 1'b1 && n < 1000) begin tick(); n++; if (ss0 !== 1'b1) ssbad++; end
    check("pulse_len", n, 160);
    n = 0;
    while (ready0 !== 1'b1 && n < 3000) begin tick(); n++; if (ss0 !== 1'b1) ssbad++; end
    check("wait_len", n, 1600);
    check("ss_high_in_reset", ssbad, 0);
    check("idle_busy", busy0, 0);

    // Single byte 0xA5, command
    data0 = 8'hA5; dc0 = 1'b0; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    check("a5_ss_low", ss0, 0);
    check("a5_ready_low", ready0, 0);
    check("a5_mosi_msb", mosi0, 1);
    check("a5_scl_low", scl0, 0);
    check("a5_busy", busy0, 1);
    r = all_rises0; n = 0;
    while (ready0 !== 1'b1 && n < 200) begin tick(); n++; end
    check("a5_byte_len", n, 32);
    check("a5_rises", all_rises0 - r, 8);
    check("a5_scl_end", scl0, 0);
    got = (rx0_q.size() > 0) ? rx0_q.pop_front() : 9'h1FF;
    check("a5_rx", got, 9'h0A5);
    n = 0;
    while (ss0 !== 1'b1 && n < 100) begin tick(); n++; end
    check("a5_cs_idle", n, 16);
    check("a5_idle_ready", ready0, 1);
    check("a5_idle_busy", busy0, 0);

    // Accept exactly on the CS timeout cycle: accept wins
    data0 = 8'hC3; dc0 = 1'b1; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    n = 0;
    while (ready0 !== 1'b1 && n < 200) begin tick(); n++; end
    check("c3_byte_len", n, 32);
    sshigh = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (ss0 !== 1'b0) sshigh++; end
    data0 = 8'h18; dc0 = 1'b0; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    check("tmo_ss_low", ss0, 0);
    check("tmo_ready_low", ready0, 0);
    check("tmo_dc", dc_out0, 0);
    check("tmo_no_ss_rise", sshigh, 0);
    n = 0;
    while (ready0 !== 1'b1 && n < 200) begin tick(); n++; end
    n = 0;
    while (ss0 !== 1'b1 && n < 100) begin tick(); n++; end
    got = (rx0_q.size() > 0) ? rx0_q.pop_front() : 9'h0FF;
    check("tmo_rx0", got, 9'h1C3);
    got = (rx0_q.size() > 0) ? rx0_q.pop_front() : 9'h1FF;
    check("tmo_rx1", got, 9'h018);

    // Back-to-back 0x81 (cmd) then 0xFF (data), second held until HOLD
    data0 = 8'h81; dc0 = 1'b0; valid0 = 1'b1;
    tick();
    data0 = 8'hFF; dc0 = 1'b1;
    sshigh = 0; n = 0;
    while (ready0 !== 1'b1 && n < 200) begin tick(); n++; if (ss0 !== 1'b0) sshigh++; end
    check("b2b_dc_before_load", dc_out0, 0);
    tick();
    valid0 = 1'b0;
    check("b2b_dc_after_load", dc_out0, 1);
    check("b2b_ready_low", ready0, 0);
    n = 0;
    while (ready0 !== 1'b1 && n < 200) begin tick(); n++; if (ss0 !== 1'b0) sshigh++; end
    check("b2b_byte2_len", n, 32);
    check("b2b_no_ss_rise", sshigh, 0);
    n = 0;
    while (ss0 !== 1'b1 && n < 100) begin tick(); n++; end
    got = (rx0_q.size() > 0) ? rx0_q.pop_front() : 9'h1FF;
    check("b2b_rx0", got, 9'h081);
    got = (rx0_q.size() > 0) ? rx0_q.pop_front() : 9'h000;
    check("b2b_rx1", got, 9'h1FF);
    check("dc_stable_in_byte", dcbad0, 0);

    // rst_req_i during bit 4 of 0x3C
    data0 = 8'h3C; dc0 = 1'b0; valid0 = 1'b1;
    r = all_rises0;
    tick();
    valid0 = 1'b0;
    repeat (17) tick();
    check("req_rises_before", all_rises0 - r, 4);
    rst_req0 = 1'b1;
    tick();
    rst_req0 = 1'b0;
    check("req_ss_high", ss0, 1);
    check("req_scl_low", scl0, 0);
    check("req_ready_low", ready0, 0);
    check("req_oled_rst_low", oled_rst0, 0);
    check("req_busy", busy0, 1);
    r = all_rises0; n = 0;
    while (oled_rst0 !== 1'b1 && n < 1000) begin tick(); n++; end
    check("req_pulse_len", n, 160);
    n = 0;
    while (ready0 !== 1'b1 && n < 3000) begin tick(); n++; end
    check("req_wait_len", n, 1600);
    check("req_no_sck", all_rises0 - r, 0);
    check("req_byte_dropped", rx0_q.size(), 0);

    // rst_req_i coincident with an accept
    data0 = 8'h55; dc0 = 1'b1; valid0 = 1'b1; rst_req0 = 1'b1;
    r = all_rises0;
    tick();
    rst_req0 = 1'b0; valid0 = 1'b0;
    check("coin_ss_high", ss0, 1);
    check("coin_ready_low", ready0, 0);
    check("coin_oled_rst_low", oled_rst0, 0);
    n = 0;
    while (oled_rst0 !== 1'b1 && n < 1000) begin tick(); n++; end
    check("coin_pulse_len", n, 160);
    n = 0;
    while (ready0 !== 1'b1 && n < 3000) begin tick(); n++; end
    check("coin_no_sck", all_rises0 - r, 0);
    check("coin_byte_dropped", rx0_q.size(), 0);
    check("sck_quiet_cs_high0", sclbad0, 0);

    // CLK_DIV=1 random stream of 64 bytes with random gaps
    timeouts = 0;
    for (int i = 0; i < 64; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      data1  = 8'($urandom);
      dc1    = 1'($urandom_range(0, 1));
      valid1 = 1'b1;
      exp_q.push_back({dc1, data1});
      acc = 1'b0; n = 0;
      while (!acc && n < 100) begin acc = ready1; tick(); n++; end
      if (!acc) timeouts++;
      valid1 = 1'b0;
    end
    n = 0;
    while (ss1 !== 1'b1 && n < 200) begin tick(); n++; end
    check("stream_timeouts", timeouts, 0);
    check("stream_count", rx1_q.size(), 64);
    for (int i = 0; i < 64; i++) begin
      exp_b = exp_q.pop_front();
      got   = (rx1_q.size() > 0) ? rx1_q.pop_front() : ~exp_b;
      check($sformatf("stream_byte%0d", i), got, exp_b);
    end
    check("stream_sck_quiet_cs_high", sclbad1, 0);
    check("stream_dc_stable", dcbad1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
